// File: rtl/timer_bus_arb_pkg.sv
// rtl/timer_bus_arb_pkg.sv - shared constants and types for the timer register-port arbiter
package timer_bus_arb_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_WRITE = 2'd1,
      OP_READ  = 2'd2
   } timer_op_e;

   localparam logic [31:0] MTIMECMP_BASE = 32'h0200_4000;
   localparam logic [31:0] MTIMECMP_HI   = MTIMECMP_BASE + 32'd4;
   localparam logic [31:0] MTIME_BASE    = 32'h0200_BFF8;

   typedef enum logic {
      MST0 = 1'b0,
      MST1 = 1'b1
   } mst_e;

   function automatic mst_e other_mst(input mst_e m);
      return (m == MST0) ? MST1 : MST0;
   endfunction

endpackage

// File: rtl/timer_bus_arb_rr_arb2.sv
// rtl/timer_bus_arb_rr_arb2.sv - two-way round-robin grant with pointer register
module rr_arb2
   import timer_bus_arb_pkg::*;
(
   input  logic       clk,
   input  logic       resetb,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   mst_e ptr_q, ptr_d;
   logic ptr_b, alt_b;

   assign ptr_b = ptr_q;
   assign alt_b = other_mst(ptr_q);

   always_ff @(posedge clk) begin
      if (!resetb) begin
         ptr_q <= MST0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      gnt = 2'b00;
      if (req[ptr_b]) begin
         gnt[ptr_b] = 1'b1;
      end else if (req[alt_b]) begin
         gnt[alt_b] = 1'b1;
      end
   end

   // After an accept the pointer favours whichever master did not just win.
   always_comb begin
      ptr_d = ptr_q;
      if (accept && (gnt != 2'b00)) begin
         ptr_d = gnt[1] ? MST0 : MST1;
      end
   end

endmodule

// File: rtl/timer_bus_arb.sv
// rtl/timer_bus_arb.sv - two-master arbiter for the machine timer register port
// Optional master-0 write lock is built when TIMER_BUS_ARB_LOCK_EN is defined.
module timer_bus_arb
   import timer_bus_arb_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int LOCK_MAX = 16
) (
   input  logic          clk,
   input  logic          resetb,
   input  logic          m0_wready,
   output logic          m0_wvalid,
   input  logic [AW-1:0] m0_waddr,
   input  logic [DW-1:0] m0_wdata,
   input  logic [3:0]    m0_wstrb,
   input  logic          m0_wlock,
   input  logic          m0_rready,
   output logic          m0_rvalid,
   input  logic [AW-1:0] m0_raddr,
   output logic          m0_rresp,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_wready,
   output logic          m1_wvalid,
   input  logic [AW-1:0] m1_waddr,
   input  logic [DW-1:0] m1_wdata,
   input  logic [3:0]    m1_wstrb,
   input  logic          m1_rready,
   output logic          m1_rvalid,
   input  logic [AW-1:0] m1_raddr,
   output logic          m1_rresp,
   output logic [DW-1:0] m1_rdata,
   output logic          s_wready,
   output logic [AW-1:0] s_waddr,
   output logic [DW-1:0] s_wdata,
   output logic [3:0]    s_wstrb,
   input  logic          s_wvalid,
   output logic          s_rready,
   output logic [AW-1:0] s_raddr,
   input  logic          s_rvalid,
   input  logic          s_rresp,
   input  logic [DW-1:0] s_rdata
);

   logic [1:0] wreq, wgnt, rreq, rgnt;
   logic       w_accept, r_accept;
   logic       pend_q, pend_d;
   mst_e       owner_q, owner_d;
   logic       resp_ok;

`ifdef TIMER_BUS_ARB_LOCK_EN
   localparam int LCW = $clog2(LOCK_MAX + 1);

   logic           lock_q, lock_d;
   logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
   logic           m0_w_acc;

   // Masking master 1 while locked leaves master 0 as the only candidate.
   assign wreq = {m1_wready & ~lock_q, m0_wready} & {2{resetb}};
   assign m0_w_acc = wgnt[0] & s_wvalid;

   always_ff @(posedge clk) begin
      if (!resetb) begin
         lock_q     <= 1'b0;
         lock_cnt_q <= '0;
      end else begin
         lock_q     <= lock_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   always_comb begin
      lock_d     = lock_q;
      lock_cnt_d = lock_cnt_q;
      if (m0_w_acc) begin
         lock_d     = m0_wlock;
         lock_cnt_d = '0;
      end else if (lock_q) begin
         if (lock_cnt_q == LCW'(LOCK_MAX - 1)) begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
         end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
         end
      end
   end
`else
   logic unused_wlock;

   assign wreq = {m1_wready, m0_wready} & {2{resetb}};
   assign unused_wlock = m0_wlock & (LOCK_MAX > 0);
`endif

   assign rreq = {m1_rready, m0_rready} & {2{resetb}};

   rr_arb2 u_warb (
      .clk    (clk),
      .resetb (resetb),
      .req    (wreq),
      .accept (w_accept),
      .gnt    (wgnt)
   );

   rr_arb2 u_rarb (
      .clk    (clk),
      .resetb (resetb),
      .req    (rreq),
      .accept (r_accept),
      .gnt    (rgnt)
   );

   assign s_wready  = |wgnt;
   assign s_waddr   = wgnt[1] ? m1_waddr : m0_waddr;
   assign s_wdata   = wgnt[1] ? m1_wdata : m0_wdata;
   assign s_wstrb   = wgnt[1] ? m1_wstrb : m0_wstrb;
   assign w_accept  = s_wready & s_wvalid;
   assign m0_wvalid = wgnt[0] & s_wvalid;
   assign m1_wvalid = wgnt[1] & s_wvalid;

   assign s_rready  = |rgnt;
   assign s_raddr   = rgnt[1] ? m1_raddr : m0_raddr;
   assign r_accept  = s_rready & s_rvalid;
   assign m0_rvalid = rgnt[0] & s_rvalid;
   assign m1_rvalid = rgnt[1] & s_rvalid;

   always_ff @(posedge clk) begin
      if (!resetb) begin
         pend_q  <= 1'b0;
         owner_q <= MST0;
      end else begin
         pend_q  <= pend_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      pend_d  = r_accept;
      owner_d = owner_q;
      if (r_accept) begin
         owner_d = rgnt[1] ? MST1 : MST0;
      end
   end

   // A response with nothing outstanding is swallowed.
   assign resp_ok  = s_rresp & pend_q & resetb;
   assign m0_rresp = resp_ok & (owner_q == MST0);
   assign m1_rresp = resp_ok & (owner_q == MST1);
   assign m0_rdata = s_rdata;
   assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_timer_bus_arb.sv
// tb/tb_timer_bus_arb.sv - self-checking bench for timer_bus_arb with a small timer model
module tb_timer_bus_arb;
   import timer_bus_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic resetb;
   logic m0_wready, m0_wvalid, m0_wlock, m0_rready, m0_rvalid, m0_rresp;
   logic m1_wready, m1_wvalid, m1_rready, m1_rvalid, m1_rresp;
   logic [AW-1:0] m0_waddr, m0_raddr, m1_waddr, m1_raddr, s_waddr, s_raddr;
   logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
   logic [3:0] m0_wstrb, m1_wstrb, s_wstrb;
   logic s_wready, s_wvalid, s_rready, s_rvalid, s_rresp;
   logic inject;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   timer_bus_arb #(.AW(AW), .DW(DW), .LOCK_MAX(16)) dut (
      .clk(clk), .resetb(resetb),
      .m0_wready(m0_wready), .m0_wvalid(m0_wvalid), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_wlock(m0_wlock), .m0_rready(m0_rready), .m0_rvalid(m0_rvalid),
      .m0_raddr(m0_raddr), .m0_rresp(m0_rresp), .m0_rdata(m0_rdata),
      .m1_wready(m1_wready), .m1_wvalid(m1_wvalid), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_rready(m1_rready), .m1_rvalid(m1_rvalid),
      .m1_raddr(m1_raddr), .m1_rresp(m1_rresp), .m1_rdata(m1_rdata),
      .s_wready(s_wready), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_wvalid(s_wvalid), .s_rready(s_rready), .s_raddr(s_raddr), .s_rvalid(s_rvalid),
      .s_rresp(s_rresp), .s_rdata(s_rdata)
   );

   // Timer model: free-running mtime, read data returned one cycle after accept.
   logic [31:0] mtime_r = 32'd0;
   logic [31:0] cmp_lo = 32'd0;
   logic [31:0] cmp_hi = 32'd0;
   logic [31:0] rdata_q = 32'd0;
   logic        rresp_q = 1'b0;

   function automatic logic [31:0] sl_read(input logic [31:0] a);
      if (a == MTIME_BASE) return mtime_r;
      if (a == MTIMECMP_BASE) return cmp_lo;
      if (a == MTIMECMP_HI) return cmp_hi;
      return 32'hDEAD_BEEF;
   endfunction

   always_ff @(posedge clk) begin
      mtime_r <= mtime_r + 32'd1;
      if (s_wready && s_wvalid) begin
         if (s_waddr == MTIME_BASE) mtime_r <= s_wdata;
         if (s_waddr == MTIMECMP_BASE) cmp_lo <= s_wdata;
         if (s_waddr == MTIMECMP_HI) cmp_hi <= s_wdata;
      end
      rresp_q <= s_rready && s_rvalid;
      if (s_rready && s_rvalid) rdata_q <= sl_read(s_raddr);
   end

   assign s_rresp = rresp_q | inject;
   assign s_rdata = rdata_q;

   typedef struct {
      logic [31:0] data;
      int          due;
      logic        owner;
      int          mode;
   } sb_t;

   sb_t sb[$];

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s actual=%0h required=%0h", nm, fld, act, exp);
      end
   endtask

   // Response monitor: every cycle the rresp pair must match the head of the scoreboard.
   always @(negedge clk) begin : sb_mon
      sb_t it;
      logic e0, e1;
      logic [31:0] got;
      e0 = 1'b0;
      e1 = 1'b0;
      if (sb.size() > 0 && sb[0].due < cyc) begin
         it = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL sb_stale due=%0d now=%0d", it.due, cyc);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         it = sb.pop_front();
         e0 = ~it.owner;
         e1 = it.owner;
         got = it.owner ? m1_rdata : m0_rdata;
         if (it.mode == 0) begin
            chk("rdata", "exact", got, it.data);
         end else begin
            checks++;
            if (got < it.data || got >= it.data + 32'd16) begin
               errors++;
               $display("FAIL rdata range actual=%0h required=[%0h,+16)", got, it.data);
            end
         end
      end
      chk("rresp", "m0_rresp", 32'(m0_rresp), 32'(e0));
      chk("rresp", "m1_rresp", 32'(m1_rresp), 32'(e1));
   end

   task automatic cyc_chk(input string nm, input logic e0w, input logic e1w, input logic e0r,
                          input logic e1r, input logic [31:0] rexp, input int mode);
      sb_t it;
      @(negedge clk);
      chk(nm, "m0_wvalid", 32'(m0_wvalid), 32'(e0w));
      chk(nm, "m1_wvalid", 32'(m1_wvalid), 32'(e1w));
      chk(nm, "m0_rvalid", 32'(m0_rvalid), 32'(e0r));
      chk(nm, "m1_rvalid", 32'(m1_rvalid), 32'(e1r));
      if ((e0r || e1r) && mode >= 0) begin
         it.data  = rexp;
         it.due   = cyc + 1;
         it.owner = e1r;
         it.mode  = mode;
         sb.push_back(it);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // {w0,w1,r0,r1} {swv,srv} {e0w,e1w,e0r,e1r} {e_swready}
   typedef struct packed {
      logic w0, w1, r0, r1, swv, srv, e0w, e1w, e0r, e1r, eswr;
   } vec_t;

   vec_t tbl[17];

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      tbl[0]  = 11'b0011_11_0010_0;
      tbl[1]  = 11'b0011_11_0001_0;
      tbl[2]  = 11'b0011_11_0010_0;
      tbl[3]  = 11'b0011_11_0001_0;
      tbl[4]  = 11'b0010_11_0010_0;
      tbl[5]  = 11'b0010_11_0010_0;
      tbl[6]  = 11'b0001_11_0001_0;
      tbl[7]  = 11'b0011_10_0000_0;
      tbl[8]  = 11'b0011_11_0010_0;
      tbl[9]  = 11'b1100_11_1000_1;
      tbl[10] = 11'b1100_01_0000_1;
      tbl[11] = 11'b1100_11_0100_1;
      tbl[12] = 11'b0100_11_0100_1;
      tbl[13] = 11'b0000_11_0000_0;
      tbl[14] = 11'b1001_11_1001_1;
      tbl[15] = 11'b0110_11_0110_1;
      tbl[16] = 11'b1111_11_1001_1;

      resetb = 1'b0;
      inject = 1'b0;
      s_wvalid = 1'b1;
      s_rvalid = 1'b1;
      m0_wlock = 1'b0;
      m0_wready = 1'b1; m1_wready = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
      m0_waddr = MTIMECMP_BASE; m0_wdata = 32'h100; m0_wstrb = 4'hF;
      m1_waddr = MTIME_BASE;    m1_wdata = 32'h50;  m1_wstrb = 4'h3;
      m0_raddr = MTIMECMP_BASE; m1_raddr = MTIME_BASE;

      for (int i = 0; i < 2; i++) begin
         cyc_chk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, -1);
         chk("reset", "s_wready", 32'(s_wready), 32'd0);
         chk("reset", "s_rready", 32'(s_rready), 32'd0);
         adv();
      end

      resetb = 1'b1;
      m0_rready = 1'b0; m1_rready = 1'b0;
      cyc_chk("cw0", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, -1);
      chk("cw0", "s_waddr", s_waddr, MTIMECMP_BASE);
      chk("cw0", "s_wdata", s_wdata, 32'h100);
      adv();
      m0_wready = 1'b0;
      cyc_chk("cw1", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, -1);
      chk("cw1", "s_waddr", s_waddr, MTIME_BASE);
      chk("cw1", "s_wdata", s_wdata, 32'h50);
      chk("cw1", "s_wstrb", 32'(s_wstrb), 32'h3);
      adv();
      m1_wready = 1'b0;
      m0_rready = 1'b1; m1_rready = 1'b1;
      cyc_chk("rb0", 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 0);
      adv();
      m0_rready = 1'b0;
      cyc_chk("rb1", 1'b0, 1'b0, 1'b0, 1'b1, 32'h50, 1);
      adv();
      m1_rready = 1'b0;

      m0_waddr = MTIMECMP_HI; m0_wdata = 32'hAAAA;
      m1_waddr = MTIMECMP_HI; m1_wdata = 32'hBBBB;
      m0_raddr = MTIMECMP_BASE; m1_raddr = MTIMECMP_BASE;
      for (int i = 0; i < 17; i++) begin
         m0_wready = tbl[i].w0; m1_wready = tbl[i].w1;
         m0_rready = tbl[i].r0; m1_rready = tbl[i].r1;
         s_wvalid = tbl[i].swv; s_rvalid = tbl[i].srv;
         cyc_chk($sformatf("row%0d", i), tbl[i].e0w, tbl[i].e1w, tbl[i].e0r, tbl[i].e1r, 32'h100, 0);
         chk($sformatf("row%0d", i), "s_wready", 32'(s_wready), 32'(tbl[i].eswr));
         adv();
      end
      m0_wready = 1'b0; m1_wready = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
      s_wvalid = 1'b1; s_rvalid = 1'b1;

      cyc_chk("idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, -1);
      adv();
      inject = 1'b1;
      cyc_chk("spurious", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, -1);
      adv();
      inject = 1'b0;

      m0_raddr = MTIMECMP_HI; m0_rready = 1'b1;
      m1_waddr = MTIMECMP_HI; m1_wdata = 32'h1; m1_wready = 1'b1;
      cyc_chk("ovl", 1'b0, 1'b1, 1'b1, 1'b0, 32'hAAAA, 0);
      adv();
      m1_wready = 1'b0;
      cyc_chk("ovl_new", 1'b0, 1'b0, 1'b1, 1'b0, 32'h1, 0);
      adv();

      m0_waddr = MTIMECMP_HI; m0_wdata = 32'h1; m0_wready = 1'b1;
      cyc_chk("rst_rd", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, -1);
      adv();
      resetb = 1'b0;
      m1_wready = 1'b1; m1_rready = 1'b1;
      cyc_chk("in_rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, -1);
      chk("in_rst", "s_wready", 32'(s_wready), 32'd0);
      chk("in_rst", "s_rready", 32'(s_rready), 32'd0);
      adv();
      resetb = 1'b1;
      cyc_chk("post_rst", 1'b1, 1'b0, 1'b1, 1'b0, 32'h1, 0);
      adv();
      m0_wready = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;

      m1_waddr = MTIME_BASE; m1_wdata = 32'h77;
      cyc_chk("pre_lock", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, -1);
      adv();
      m0_waddr = MTIMECMP_BASE; m0_wdata = 32'hFFFF; m0_wlock = 1'b1; m0_wready = 1'b1;
      cyc_chk("lock_lo", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, -1);
      adv();
      m0_wready = 1'b0; m0_wlock = 1'b0;
      m1_raddr = MTIMECMP_BASE; m1_rready = 1'b1;
`ifdef TIMER_BUS_ARB_LOCK_EN
      cyc_chk("locked1", 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF, 0);
      adv();
      m1_rready = 1'b0;
      cyc_chk("locked2", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, -1);
      adv();
      m0_waddr = MTIMECMP_HI; m0_wdata = 32'h0; m0_wready = 1'b1;
      cyc_chk("lock_hi", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, -1);
      adv();
      m0_wready = 1'b0;
      cyc_chk("unlocked", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, -1);
      adv();
      m0_waddr = MTIMECMP_BASE; m0_wlock = 1'b1; m0_wready = 1'b1;
      cyc_chk("lock_again", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, -1);
      adv();
      m0_wready = 1'b0; m0_wlock = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         cyc_chk($sformatf("stall%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, -1);
         adv();
      end
      cyc_chk("timeout", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, -1);
      adv();
`else
      cyc_chk("nolock_m1", 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF, 0);
      adv();
      m1_rready = 1'b0; m1_wready = 1'b0;
      m0_waddr = MTIMECMP_HI; m0_wdata = 32'h0; m0_wready = 1'b1;
      cyc_chk("nolock_hi", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, -1);
      adv();
`endif
      m0_wready = 1'b0; m1_wready = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
      cyc_chk("drain", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, -1);
      adv();
      chk("end", "sb_left", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
